aes_core_scheduler: RTL

- Shares one iterative Cipher instance and one iterative InvCipher instance between two requesters: an encrypt channel and a decrypt channel.
- Arbitrates between the channels round-robin and latches the input block.
- Sequences the selected core's reset and round count, then captures the result and presents it on a valid/ready output channel tagged with the operation type.
- Replaces the ad-hoc count-based sequencing in the top level; the key schedule is supplied externally to the cores and is not handled here.

---
 rtl/aes_core_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one iterative Cipher and one InvCipher core between encrypt/decrypt channels.
// Define AES_OP_COUNTER_EN to add saturating per-type result handshake counters (enc_count/dec_count).
module aes_core_scheduler #(
    parameter int Nk           = 4,
    parameter int Nr           = Nk + 6,
    parameter int CORE_LATENCY = Nr + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enc_valid,
    output logic           enc_ready,
    input  logic [0:127]   enc_text,
    input  logic           dec_valid,
    output logic           dec_ready,
    input  logic [0:127]   dec_text,
    output logic           c_reset,
    output logic [127:0]   c_text_in,
    input  logic [127:0]   c_text_out,
    output logic           ic_reset,
    output logic [127:0]   ic_text_in,
    input  logic [127:0]   ic_text_out,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [127:0]   res_text,
    output logic           res_is_dec,
`ifdef AES_OP_COUNTER_EN
    output logic           busy,
    output logic [15:0]    enc_count,
    output logic [15:0]    dec_count
`else
    output logic           busy
`endif
);

    localparam int CntW = $clog2(CORE_LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic              opDec;
    logic              lastGrantDec;
    logic              grantEnc;
    logic              grantDec;

    // Encrypt wins when alone or when decrypt was granted last.
    always_comb begin
        grantEnc  = enc_valid && (!dec_valid || lastGrantDec);
        grantDec  = dec_valid && !grantEnc;
        enc_ready = (state == IDLE) && grantEnc;
        dec_ready = (state == IDLE) && grantDec;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            opDec        <= 1'b0;
            lastGrantDec <= 1'b1;
            res_valid    <= 1'b0;
            res_text     <= '0;
            res_is_dec   <= 1'b0;
            c_reset      <= 1'b1;
            ic_reset     <= 1'b1;
            c_text_in    <= '0;
            ic_text_in   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantEnc) begin
                        c_text_in    <= enc_text;
                        opDec        <= 1'b0;
                        lastGrantDec <= 1'b0;
                        state        <= LOAD;
                    end else if (grantDec) begin
                        ic_text_in   <= dec_text;
                        opDec        <= 1'b1;
                        lastGrantDec <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= RUN;
                    if (opDec) ic_reset <= 1'b0;
                    else       c_reset  <= 1'b0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CntW'(CORE_LATENCY - 1)) begin
                        res_text   <= opDec ? ic_text_out : c_text_out;
                        res_is_dec <= opDec;
                        res_valid  <= 1'b1;
                        c_reset    <= 1'b1;
                        ic_reset   <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_OP_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            dec_count <= '0;
        end else if (state == HOLD && res_ready) begin
            if (res_is_dec) begin
                if (dec_count != 16'hFFFF) dec_count <= dec_count + 16'd1;
            end else begin
                if (enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
            end
        end
    end
`endif

endmodule
